bus_mux_keeper: RTL and testbench

Parametrised successor to the datapath bus multiplexer. Selects one of NUM_SRC source words onto a WIDTH-bit bus. The select is a one-hot drive vector from the control unit, with lowest index winning. Adds an optional output register stage, a bus keeper that holds the last driven value when no source drives, owner tracking, and multi-driver conflict detection with a saturating counter. Sits between all register/HI/LO/Z/PC/MDR/port/immediate outputs and every bus-loaded register.

---
 rtl/bus_pkg.sv | 41 ++++
 rtl/bus_prio_enc.sv | 37 +++
 rtl/bus_mux_keeper.sv | 152 +++++++++++++++
 tb/tb_bus_mux_keeper.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants, the bus word type and the index-width helper for the bus multiplexer.
// Conflict detection in bus_mux_keeper is enabled with the BUS_CONFLICT_CHECK_EN macro.
package bus_pkg;

    localparam int BUS_WIDTH   = 32;
    localparam int BUS_NUM_SRC = 24;

    // Bus source indices, in the order the control unit drives them.
    localparam int R0     = 0;
    localparam int R1     = 1;
    localparam int R2     = 2;
    localparam int R3     = 3;
    localparam int R4     = 4;
    localparam int R5     = 5;
    localparam int R6     = 6;
    localparam int R7     = 7;
    localparam int R8     = 8;
    localparam int R9     = 9;
    localparam int R10    = 10;
    localparam int R11    = 11;
    localparam int R12    = 12;
    localparam int R13    = 13;
    localparam int R14    = 14;
    localparam int R15    = 15;
    localparam int HI     = 16;
    localparam int LO     = 17;
    localparam int ZHIGH  = 18;
    localparam int ZLOW   = 19;
    localparam int PC     = 20;
    localparam int MDR    = 21;
    localparam int INPORT = 22;
    localparam int CSIGN  = 23;

    typedef logic [BUS_WIDTH-1:0] bus_word_t;

    // A source index always needs at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Lowest-index-wins priority encoder over a drive-enable vector.
// The multi-driver flag is only built when DETECT_MULTI is set.
module bus_prio_enc
    import bus_pkg::*;
#(
    parameter int N            = BUS_NUM_SRC,
    parameter bit DETECT_MULTI = 1'b1,
    parameter int IDX_W        = idx_width(N)
) (
    input  logic [N-1:0]     sel,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Scanning downward lets the lowest set bit overwrite every higher one.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |sel;

    generate
        if (DETECT_MULTI) begin : g_multi
            // Clearing the lowest set bit leaves something only if two or more were set.
            assign multi = |(sel & (sel - N'(1)));
        end else begin : g_no_multi
            assign multi = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/bus_mux_keeper.sv
// One-hot bus multiplexer with bus keeper, owner tracking and optional output register.
// Define BUS_CONFLICT_CHECK_EN to enable multi-driver conflict flag, sticky bit and counter.
module bus_mux_keeper
    import bus_pkg::*;
#(
    parameter int WIDTH   = BUS_WIDTH,
    parameter int NUM_SRC = BUS_NUM_SRC,
    parameter bit REG_OUT = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic                                clock,
    input  logic                                clear,
    input  logic [NUM_SRC*WIDTH-1:0]            bus_in,
    input  logic [NUM_SRC-1:0]                  sel,
    input  logic                                clr_conflict,
    output logic [WIDTH-1:0]                    bus_out,
    output logic                                bus_valid,
    output logic [idx_width(NUM_SRC)-1:0]       owner,
    output logic                                conflict,
    output logic                                conflict_sticky,
    output logic [CNT_W-1:0]                    conflict_count
);

    localparam int OWN_W = idx_width(NUM_SRC);

`ifdef BUS_CONFLICT_CHECK_EN
    localparam bit DETECT_MULTI = 1'b1;
`else
    localparam bit DETECT_MULTI = 1'b0;
`endif

    logic [OWN_W-1:0] win_idx;
    logic             any_sel;
    logic             multi;
    logic [WIDTH-1:0] win_word;

    logic [WIDTH-1:0] hold_d, hold_q;
    logic [OWN_W-1:0] own_d, own_q;

    bus_prio_enc #(
        .N            (NUM_SRC),
        .DETECT_MULTI (DETECT_MULTI),
        .IDX_W        (OWN_W)
    ) u_prio_enc (
        .sel   (sel),
        .idx   (win_idx),
        .any   (any_sel),
        .multi (multi)
    );

    // Data follows the winning index only; a conflict never ORs source words together.
    always_comb begin
        win_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win_idx == OWN_W'(i)) begin
                win_word = bus_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        hold_d = hold_q;
        own_d  = own_q;
        if (any_sel) begin
            hold_d = win_word;
            own_d  = win_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            hold_q <= '0;
            own_q  <= '0;
        end else begin
            hold_q <= hold_d;
            own_q  <= own_d;
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic valid_d, valid_q;
            logic conf_d, conf_q;

            always_comb begin
                valid_d = any_sel;
                conf_d  = multi;
            end

            always_ff @(posedge clock) begin
                if (clear) begin
                    valid_q <= 1'b0;
                    conf_q  <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                    conf_q  <= conf_d;
                end
            end

            assign bus_out   = hold_q;
            assign owner     = own_q;
            assign bus_valid = valid_q;
            assign conflict  = conf_q;
        end else begin : g_comb_out
            // The live selection shows through even during a clear cycle.
            assign bus_out   = any_sel ? win_word : hold_q;
            assign owner     = any_sel ? win_idx : own_q;
            assign bus_valid = any_sel;
            assign conflict  = multi;
        end
    endgenerate

`ifdef BUS_CONFLICT_CHECK_EN
    logic             sticky_d, sticky_q;
    logic [CNT_W-1:0] count_d, count_q;

    // A conflict in the same cycle as clr_conflict is recorded on top of the clear.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clr_conflict) begin
            sticky_d = multi;
            count_d  = multi ? CNT_W'(1) : '0;
        end else if (multi) begin
            sticky_d = 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign conflict_sticky = sticky_q;
    assign conflict_count  = count_q;
`else
    logic unused_conflict_in;

    assign unused_conflict_in = clr_conflict ^ multi;
    assign conflict_sticky    = 1'b0;
    assign conflict_count     = '0;
`endif

endmodule

// File: tb/tb_bus_mux_keeper.sv
// Directed bench for bus_mux_keeper: one registered instance (CNT_W=2), one combinational.
// Conflict expectations follow BUS_CONFLICT_CHECK_EN.
module tb_bus_mux_keeper;
    import bus_pkg::*;

    localparam int W  = BUS_WIDTH;
    localparam int N  = BUS_NUM_SRC;
    localparam int OW = 5;

`ifdef BUS_CONFLICT_CHECK_EN
    localparam bit CC = 1'b1;
`else
    localparam bit CC = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            clear;
    logic [N*W-1:0]  bus_in;
    logic [N-1:0]    sel_a, sel_b;
    logic            clr_a, clr_b;

    logic [W-1:0]    out_a, out_b;
    logic            valid_a, valid_b;
    logic [OW-1:0]   own_a, own_b;
    logic            conf_a, conf_b;
    logic            sticky_a, sticky_b;
    logic [1:0]      cnt_a;
    logic [7:0]      cnt_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    bus_mux_keeper #(.WIDTH(W), .NUM_SRC(N), .REG_OUT(1'b1), .CNT_W(2)) u_reg (
        .clock           (clock),
        .clear           (clear),
        .bus_in          (bus_in),
        .sel             (sel_a),
        .clr_conflict    (clr_a),
        .bus_out         (out_a),
        .bus_valid       (valid_a),
        .owner           (own_a),
        .conflict        (conf_a),
        .conflict_sticky (sticky_a),
        .conflict_count  (cnt_a)
    );

    bus_mux_keeper #(.WIDTH(W), .NUM_SRC(N), .REG_OUT(1'b0), .CNT_W(8)) u_comb (
        .clock           (clock),
        .clear           (clear),
        .bus_in          (bus_in),
        .sel             (sel_b),
        .clr_conflict    (clr_b),
        .bus_out         (out_b),
        .bus_valid       (valid_b),
        .owner           (own_b),
        .conflict        (conf_b),
        .conflict_sticky (sticky_b),
        .conflict_count  (cnt_b)
    );

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic clr, input logic ca, input logic cb);
        sel_a = a;
        sel_b = b;
        clear = clr;
        clr_a = ca;
        clr_b = cb;
    endtask

    task automatic setWord(input int i, input logic [W-1:0] v);
        bus_in[i*W +: W] = v;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [N-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        bus_in = '0;

        // Reset for two cycles, then idle.
        applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("rst_out_a",    64'(out_a),    64'h0);
        checkOutput("rst_own_a",    64'(own_a),    64'h0);
        checkOutput("rst_valid_a",  64'(valid_a),  64'h0);
        checkOutput("rst_cnt_a",    64'(cnt_a),    64'h0);
        checkOutput("rst_sticky_a", 64'(sticky_a), 64'h0);
        checkOutput("rst_conf_a",   64'(conf_a),   64'h0);
        checkOutput("rst_out_b",    64'(out_b),    64'h0);
        checkOutput("rst_valid_b",  64'(valid_b),  64'h0);

        // Registered single driver: PC.
        setWord(PC, 32'h0000_0010);
        applyStimulus(one << PC, '0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("reg_latency_out", 64'(out_a), 64'h0);
        step();
        checkOutput("pc_out",   64'(out_a),   64'h10);
        checkOutput("pc_own",   64'(own_a),   64'd20);
        checkOutput("pc_valid", 64'(valid_a), 64'h1);
        checkOutput("pc_conf",  64'(conf_a),  64'h0);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("keep_out",   64'(out_a),   64'h10);
        checkOutput("keep_own",   64'(own_a),   64'd20);
        checkOutput("keep_valid", 64'(valid_a), 64'h0);

        // Conflict between R3 and MDR: R3 wins.
        setWord(R3, 32'hAAAA_0000);
        setWord(MDR, 32'h1234_5678);
        applyStimulus((one << R3) | (one << MDR), '0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("cf_out",    64'(out_a),    64'hAAAA_0000);
        checkOutput("cf_own",    64'(own_a),    64'd3);
        checkOutput("cf_valid",  64'(valid_a),  64'h1);
        checkOutput("cf_conf",   64'(conf_a),   64'(CC));
        checkOutput("cf_cnt1",   64'(cnt_a),    CC ? 64'd1 : 64'd0);
        checkOutput("cf_sticky", 64'(sticky_a), 64'(CC));
        step();
        checkOutput("cf_cnt2",   64'(cnt_a),    CC ? 64'd2 : 64'd0);
        step();
        step();
        step();
        checkOutput("cf_sat",    64'(cnt_a),    CC ? 64'd3 : 64'd0);

        // clr_conflict with no conflict.
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("clr_cnt",    64'(cnt_a),    64'h0);
        checkOutput("clr_sticky", 64'(sticky_a), 64'h0);
        checkOutput("clr_conf",   64'(conf_a),   64'h0);
        checkOutput("clr_out",    64'(out_a),    64'hAAAA_0000);

        // clr_conflict concurrent with a conflict from a saturated count.
        applyStimulus((one << R3) | (one << MDR), '0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        checkOutput("pre_cnt", 64'(cnt_a), CC ? 64'd3 : 64'd0);
        applyStimulus((one << R3) | (one << MDR), '0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("conc_cnt",    64'(cnt_a),    CC ? 64'd1 : 64'd0);
        checkOutput("conc_sticky", 64'(sticky_a), 64'(CC));
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        step();

        // Combinational instance: every source in turn, with a clear mid-sequence.
        for (int i = 0; i < N; i++) begin
            setWord(i, 32'(32'h100 + i));
        end
        for (int i = 0; i < N; i++) begin
            if (i == 12) begin
                applyStimulus('0, one << i, 1'b1, 1'b0, 1'b0);
                #1;
                checkOutput("clr_live_out", 64'(out_b), 64'h10C);
                step();
                applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
                #1;
                checkOutput("clr_keep_out",   64'(out_b),   64'h0);
                checkOutput("clr_keep_own",   64'(own_b),   64'h0);
                checkOutput("clr_keep_valid", 64'(valid_b), 64'h0);
            end
            applyStimulus('0, one << i, 1'b0, 1'b0, 1'b0);
            #1;
            checkOutput("src_out",   64'(out_b),   64'(32'h100 + i));
            checkOutput("src_own",   64'(own_b),   64'(i));
            checkOutput("src_valid", 64'(valid_b), 64'h1);
            step();
        end
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("idle_out_b",   64'(out_b),   64'h117);
        checkOutput("idle_own_b",   64'(own_b),   64'd23);
        checkOutput("idle_valid_b", 64'(valid_b), 64'h0);

        // Combinational conflict between R1 and R2.
        applyStimulus('0, (one << R1) | (one << R2), 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("bcf_out",  64'(out_b),  64'h101);
        checkOutput("bcf_own",  64'(own_b),  64'd1);
        checkOutput("bcf_conf", 64'(conf_b), 64'(CC));
        step();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("bcf_cnt",    64'(cnt_b),    CC ? 64'd1 : 64'd0);
        checkOutput("bcf_sticky", 64'(sticky_b), 64'(CC));
        checkOutput("bcf_conf0",  64'(conf_b),   64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
